uart_tx_sched: RTL
==================

Name: uart_tx_sched

Overview:
- Round-robin scheduler sharing one buart transmitter between NREQ byte producers, e.g. Forth console, debug monitor and trace port.
- Sits between the producers and the buart wr/tx_data/busy interface.
- Sequences exactly one wr pulse per byte and honours buart busy timing, including the post-reset dummy period.
- Optional packet lock keeps a multi-byte message from being interleaved with other producers' bytes.

Parameters:
- NREQ, 2, number of requesters (2..8).
- GW, $clog2(NREQ), grant index width (derived, not overridden).
- LOCK_TIMEOUT, 4095, cycles before a stalled lock is forcibly released (used only with LOCK_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- resetq  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester byte pending; held high with data stable until ack.
- req_data  in  8*NREQ  byte of requester i in bits [8i+7:8i].
- req_last  in  NREQ  byte of requester i ends its packet; 1 means single-byte / no lock.
- ack  out  NREQ  one-cycle pulse: byte of requester i taken.
- grant_id  out  GW  index of the requester last served.
- locked  out  1  packet lock held by grant_id.
- uart_wr  out  1  to buart wr.
- uart_tx_data  out  8  to buart tx_data.
- uart_busy  in  1  from buart busy.

Behaviour:
- Reset (async, resetq=0): all outputs 0; state IDLE; round-robin pointer 0; lock clear. Reset mid-byte drops uart_wr immediately and loses any pending ack; requesters retry.
- Registers are clocked on posedge clk; all outputs are registered.
- FSM states: IDLE, ISSUE, SETTLE, DRAIN.
- IDLE:
  - If uart_busy=1, stay in IDLE. This covers the 15-bit-time dummy period after buart reset.
  - Else, if locked, serve only grant_id when its req=1; other requesters wait.
  - Else pick the first i with req[i]=1, searching from the pointer upward with wrap NREQ-1 -> 0.
  - On a pick: register uart_tx_data <= byte, uart_wr <= 1, ack[i] <= 1, grant_id <= i, pointer <= (i+1) mod NREQ, locked <= ~req_last[i]. Go to ISSUE.
- ISSUE: uart_wr and ack visible for exactly this one cycle; buart samples wr at its end. Go to SETTLE with uart_wr=0, ack=0.
- SETTLE: one cycle allowing buart busy to rise; uart_busy is ignored here. Go to DRAIN.
- DRAIN: wait for uart_busy=0, then go to IDLE.
- Throughput: a byte is accepted 1 cycle after IDLE sees req & !busy. Minimum spacing between uart_wr pulses is 4 cycles plus the busy time.
- Simultaneous requests: pointer order decides; no requester waits more than NREQ-1 grants unless a lock is held.
- req dropped before ack: no ack and no byte, even if it was high on an earlier cycle.
- Locked owner with req=0: lock persists (without LOCK_TIMEOUT_EN) and all others are blocked.
- uart_tx_data holds the last byte after ISSUE.

Optional Feature:
- LOCK_TIMEOUT_EN defined:
  - A counter of width $clog2(LOCK_TIMEOUT+1) increments on each IDLE cycle with locked=1, uart_busy=0 and req[grant_id]=0.
  - The counter clears whenever a byte is issued or the lock is released.
  - When the counter reaches LOCK_TIMEOUT, locked <= 0 and the counter clears; arbitration resumes on the next cycle.
- LOCK_TIMEOUT_EN undefined: no counter; the lock releases only on a byte with req_last=1.

Test Plan:
- Reset release with uart_busy held high 100 cycles, req=2'b01 -> no uart_wr until busy falls; then uart_wr pulse 1 cycle after, tx_data=0x41, ack=2'b01, grant_id=0.
- req=2'b11 continuously, data0=0x30, data1=0x31, last=2'b11 -> uart_tx_data sequence 0x30,0x31,0x30,0x31; no two uart_wr pulses within a busy window.
- Requester 0 sends 0x48,0x49,0x0A with last only on 0x0A while req1 high (0x55) -> 0x48,0x49,0x0A, then 0x55; locked=1 during the packet.
- Single-cycle uart_wr check: busy model rising 1 cycle after wr -> exactly one wr per byte; SETTLE ignores the still-low busy.
- Async reset asserted during ISSUE -> uart_wr and ack fall without a clock edge; state IDLE, locked=0 after release.
- LOCK_TIMEOUT_EN, LOCK_TIMEOUT=16: requester 0 locks, then drops req; req1 high -> req1 acked exactly 16 idle cycles after the lock stalls, plus 1 cycle for IDLE pick. Without the macro, req1 is never acked.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one buart transmitter among NREQ byte producers.
// Optional stalled-lock release when LOCK_TIMEOUT_EN is defined.
module uart_tx_sched #(
    parameter int NREQ         = 2,
    parameter int GW           = $clog2(NREQ),
    parameter int LOCK_TIMEOUT = 4095
) (
    input  logic              clk,
    input  logic              resetq,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   ack,
    output logic [GW-1:0]     grant_id,
    output logic              locked,
    output logic              uart_wr,
    output logic [7:0]        uart_tx_data,
    input  logic              uart_busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SETTLE,
        DRAIN
    } state_t;

    state_t          state, state_n;
    logic [GW-1:0]   ptr, ptr_n;
    logic [GW-1:0]   grant_n;
    logic [NREQ-1:0] ack_n;
    logic            locked_n;
    logic            wr_n;
    logic [7:0]      data_n;
    logic            pick;
    logic [GW-1:0]   pick_id;

`ifdef LOCK_TIMEOUT_EN
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    logic [TW-1:0] to_cnt, to_cnt_n;
`endif

    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] p,
                                             input int k);
        rr_idx = GW'((int'(p) + k) % NREQ);
    endfunction

    // A held lock restricts the candidate set to its owner only.
    always_comb begin
        pick    = 1'b0;
        pick_id = '0;
        if (locked) begin
            pick    = req[grant_id];
            pick_id = grant_id;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (!pick && req[rr_idx(ptr, k)]) begin
                    pick    = 1'b1;
                    pick_id = rr_idx(ptr, k);
                end
            end
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        grant_n  = grant_id;
        ack_n    = '0;
        locked_n = locked;
        wr_n     = 1'b0;
        data_n   = uart_tx_data;
`ifdef LOCK_TIMEOUT_EN
        to_cnt_n = to_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (!uart_busy) begin
                    if (pick) begin
                        data_n   = req_data[{pick_id, 3'b000} +: 8];
                        wr_n     = 1'b1;
                        ack_n    = NREQ'(1) << pick_id;
                        grant_n  = pick_id;
                        ptr_n    = (pick_id == GW'(NREQ - 1)) ? '0
                                 : pick_id + 1'b1;
                        locked_n = ~req_last[pick_id];
                        state_n  = ISSUE;
`ifdef LOCK_TIMEOUT_EN
                        to_cnt_n = '0;
`endif
                    end
`ifdef LOCK_TIMEOUT_EN
                    else if (locked && !req[grant_id]) begin
                        if (to_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                            locked_n = 1'b0;
                            to_cnt_n = '0;
                        end else begin
                            to_cnt_n = to_cnt + 1'b1;
                        end
                    end
`endif
                end
            end
            ISSUE:  state_n = SETTLE;
            // busy may not have risen yet, so it is not looked at here
            SETTLE: state_n = DRAIN;
            DRAIN: begin
                if (!uart_busy) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state        <= IDLE;
            ptr          <= '0;
            grant_id     <= '0;
            ack          <= '0;
            locked       <= 1'b0;
            uart_wr      <= 1'b0;
            uart_tx_data <= '0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            grant_id     <= grant_n;
            ack          <= ack_n;
            locked       <= locked_n;
            uart_wr      <= wr_n;
            uart_tx_data <= data_n;
        end
    end

`ifdef LOCK_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) to_cnt <= '0;
        else         to_cnt <= to_cnt_n;
    end
`endif

endmodule
